// File: rtl/data_ram_ws.sv
// Wait-stated, byte-laned data RAM with a req/ack handshake, a registered read port and
// misaligned/out-of-range error reporting. Control state resets synchronously; arrays do not.
module data_ram_ws #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LANES       = DATA_W / 8,
  parameter int unsigned DEPTH_LOG2  = 17,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wr_en_i,
  input  logic [LANES-1:0]  byte_sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              stall_o
);

  localparam int unsigned Off   = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int unsigned Words = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'((64'd1 << Off) - 64'd1);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                  wr_q;
  logic [LANES-1:0]      bsel_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  flag_q;

  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic              do_access;
  logic              mem_we;
  logic              addr_err;
  logic [DATA_W-1:0] rd_word;

  // Any address bit above the word index means the access falls outside the banks.
  assign addr_err = (|(addr_i & AlignMask)) || (|(addr_i >> (DEPTH_LOG2 + Off)));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StBusy;
          cnt_d   = WaitInit;
        end
      end
      StBusy: begin
        if (!req_i) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control logic
  always_comb begin
    accept    = (state_q == StIdle) && req_i;
    do_access = (state_q == StBusy) && req_i && (cnt_q == 4'd0);
    mem_we    = do_access && wr_q && !flag_q && !rst_i;
    ack_d     = do_access;
    err_d     = do_access && flag_q;
    rdata_d   = rdata_q;
    if (do_access) begin
      if (flag_q) begin
        rdata_d = '0;
      end else if (!wr_q) begin
        rdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      bsel_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wr_q   <= wr_en_i;
        bsel_q <= byte_sel_i;
        flag_q <= addr_err;
      end
    end
  end

  // Pure datapath capture; only consumed under the reset-controlled flags above.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= addr_i[Off +: DEPTH_LOG2];
      wdata_q <= wdata_i;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] bank_q [Words];

    always_ff @(posedge clk_i) begin
      if (mem_we && bsel_q[i]) begin
        bank_q[idx_q] <= wdata_q[8*i +: 8];
      end
    end

    assign rd_word[8*i +: 8] = bank_q[idx_q];
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign stall_o = req_i & ~ack_q;

endmodule

// File: doc/data_ram_ws.md
# data_ram_ws

Parametrised, wait-stated successor to the single-cycle data RAM in the MEM stage of the 5-stage MIPS core. It holds `LANES` byte-wide banks with per-lane write enables. Every access goes through a req/ack handshake with a programmable wait-state count, so the pipeline can be stalled against slower memory models. It adds a registered read port, out-of-range and misalignment error reporting, abort on request withdrawal, and synchronous reset of all control state.

## Interface
- `DATA_W`, 32, data width in bits; multiple of 8.
- `LANES`, `DATA_W/8`, byte lanes; OFF = log2(LANES) low address bits select the byte.
- `DEPTH_LOG2`, 17, log2 of words per bank (128K words by default).
- `ADDR_W`, 32, byte-address width.
- `WAIT_CYCLES`, 2, extra wait states per access; range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; held with all request fields stable until `ack`.
- `wr_en`  in  1  1 = write, 0 = read.
- `byte_sel`  in  LANES  per-lane write enable; ignored on reads.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  DATA_W  write data; lane i = bits [8i+7:8i].
- `rdata`  out  DATA_W  registered read data.
- `ack`  out  1  one-cycle completion pulse (registered).
- `err`  out  1  valid with `ack`; access was rejected.
- `stall`  out  1  combinational `req & ~ack`, to the pipeline hazard unit.

## Operation
- Word index = `addr[DEPTH_LOG2+OFF-1:OFF]`.
- Error condition:
  - `addr[OFF-1:0] != 0` (misaligned), or
  - any of `addr[ADDR_W-1:DEPTH_LOG2+OFF]` set (out of range).
- FSM states IDLE, BUSY, DONE; a 4-bit counter `cnt`.
- IDLE: when `req`=1, latch `wr_en`, `byte_sel`, index, `wdata` and the error flag; set `cnt <= WAIT_CYCLES`; go to BUSY.
- BUSY:
  - If `req`=0, abort: go to IDLE, no memory update, no `ack`.
  - Else if `cnt != 0`: decrement `cnt`.
  - Else perform the access, set `ack <= 1`, set `err <= flag`, go to DONE.
- Access, no error:
  - Write: each lane with `byte_sel[i]`=1 is written; other lanes are untouched; `rdata` is unchanged.
  - Read: `rdata <=` the concatenated lanes at the index.
- Access with error: no memory update; `rdata <= 0`.
- DONE: `ack` is high for this single cycle; next edge clears `ack` and `err` and returns to IDLE unconditionally.
- A write with `byte_sel`=0 completes the handshake normally and changes nothing.
- `rdata` holds its value until the next completed read (or error, which sets it to 0).
- Memory arrays are not reset and power up undefined.

## Timing
- Reset values: state IDLE, `cnt`=0, `ack`=0, `err`=0, `rdata`=0. `stall` follows `req`.
- `rst` takes priority over all activity. Reset in BUSY or DONE drops the pending access; no write occurs on the reset edge.
- Latency: `req` first high in cycle 0 → `ack` high in cycle `WAIT_CYCLES+2`. `rdata` and `err` are valid in the same cycle.
- `stall`=1 for cycles 0..`WAIT_CYCLES+1`, and 0 in the ack cycle.
- Requester must advance or drop `req` at the end of the ack cycle.
- Throughput: back-to-back requests complete one per `WAIT_CYCLES+3` cycles. The cycle after DONE is IDLE, and a new request is sampled at its end.
- Changing request fields while BUSY is illegal. Fields are latched at accept, so later changes have no effect.

## Test plan
- WAIT_CYCLES=2:
  - Write 0xDEADBEEF, byte_sel=1111, addr 0x10 → `ack` only in cycle 4; `stall` high in cycles 0–3.
  - Then read addr 0x10 → rdata=0xDEADBEEF, err=0.
- Partial write: byte_sel=0101, wdata 0x11223344 to addr 0x10 holding 0xDEADBEEF → readback 0xDE22BE44.
- WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 → `ack` in cycles 2 and 5; rdata updates only at each ack.
- DEPTH_LOG2=4:
  - Write addr 0x40 → ack with err=1; word 0 is unchanged on readback.
  - Read addr 0x2 → err=1, rdata=0.
- Write to addr 0x8 with `req` dropped in BUSY at cnt=1 → no ack, memory unchanged.
- Write to addr 0x8 with `rst` pulsed in BUSY → ack=0, rdata=0, state IDLE; a fresh read of 0x8 returns the old data.
